// File: rtl/ber_readout.sv
// BER counter readout: a host snapshots the four 64-bit BER counters and LED status,
// then reads the frozen snapshot back one 32-bit word at a time through a handshake.
module ber_readout #(
    parameter int NB_BER_CNT = 64,
    parameter int NB_WORD    = 32,
    parameter int NB_LEDS    = 4
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [NB_BER_CNT-1:0] i_ber_samp_I,
    input  logic [NB_BER_CNT-1:0] i_ber_samp_Q,
    input  logic [NB_BER_CNT-1:0] i_ber_error_I,
    input  logic [NB_BER_CNT-1:0] i_ber_error_Q,
    input  logic [NB_LEDS-1:0]    i_leds,
    input  logic                  i_cmd_valid,
    input  logic [4:0]            i_cmd,
    input  logic                  i_rack,
    output logic [NB_WORD-1:0]    o_rdata,
    output logic                  o_rvalid,
    output logic                  o_rerr,
    output logic                  o_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SNAP = 2'd1;
    localparam logic [1:0] READ = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]            state;
    logic [3:0]            addr;
    logic [NB_BER_CNT-1:0] snap_samp_i;
    logic [NB_BER_CNT-1:0] snap_samp_q;
    logic [NB_BER_CNT-1:0] snap_err_i;
    logic [NB_BER_CNT-1:0] snap_err_q;
    logic [NB_LEDS-1:0]    snap_leds;
    logic                  snap_valid;
    logic [15:0]           snap_cnt;
    logic [15:0]           snap_cnt_next;
    logic [NB_WORD-1:0]    rd_word;
    logic                  rd_err;

    assign snap_cnt_next = snap_cnt + 16'd1;
    assign o_busy        = (state != IDLE);

    function automatic logic [NB_WORD-1:0] status_word(input logic [15:0] cnt,
                                                       input logic [NB_LEDS-1:0] leds,
                                                       input logic valid);
        logic [NB_WORD-1:0] w;
        w        = '0;
        w[31:16] = cnt;
        w[4:1]   = leds[3:0];
        w[0]     = valid;
        return w;
    endfunction

    // Read mux looks only at snapshot registers, so live counters never leak into a response.
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        case (addr)
            4'd0: rd_word = snap_samp_i[NB_WORD-1:0];
            4'd1: rd_word = snap_samp_i[NB_BER_CNT-1:NB_WORD];
            4'd2: rd_word = snap_samp_q[NB_WORD-1:0];
            4'd3: rd_word = snap_samp_q[NB_BER_CNT-1:NB_WORD];
            4'd4: rd_word = snap_err_i[NB_WORD-1:0];
            4'd5: rd_word = snap_err_i[NB_BER_CNT-1:NB_WORD];
            4'd6: rd_word = snap_err_q[NB_WORD-1:0];
            4'd7: rd_word = snap_err_q[NB_BER_CNT-1:NB_WORD];
            4'd8: rd_word = status_word(snap_cnt, snap_leds, snap_valid);
            default: begin
                rd_word = NB_WORD'(32'hDEAD_BEEF);
                rd_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            addr        <= '0;
            snap_samp_i <= '0;
            snap_samp_q <= '0;
            snap_err_i  <= '0;
            snap_err_q  <= '0;
            snap_leds   <= '0;
            snap_valid  <= 1'b0;
            snap_cnt    <= '0;
            o_rdata     <= '0;
            o_rvalid    <= 1'b0;
            o_rerr      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        if (i_cmd[4]) begin
                            state <= SNAP;
                        end else begin
                            addr  <= i_cmd[3:0];
                            state <= READ;
                        end
                    end
                end
                SNAP: begin
                    snap_samp_i <= i_ber_samp_I;
                    snap_samp_q <= i_ber_samp_Q;
                    snap_err_i  <= i_ber_error_I;
                    snap_err_q  <= i_ber_error_Q;
                    snap_leds   <= i_leds;
                    snap_valid  <= 1'b1;
                    snap_cnt    <= snap_cnt_next;
                    o_rdata     <= status_word(snap_cnt_next, i_leds, 1'b1);
                    o_rerr      <= 1'b0;
                    state       <= RESP;
                end
                READ: begin
                    o_rdata <= rd_word;
                    o_rerr  <= rd_err;
                    state   <= RESP;
                end
                RESP: begin
                    // Data is settled on entry; o_rvalid rises one edge later, and only a
                    // visible response can be acknowledged.
                    if (o_rvalid && i_rack) begin
                        o_rvalid <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        o_rvalid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ber_readout.sv
// Directed self-checking bench for ber_readout: snapshot/read transactions,
// response hold under back-pressure, reset abort and snapshot counter wrap.
`timescale 1ns/1ps
module tb_ber_readout;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [63:0] i_ber_samp_I, i_ber_samp_Q, i_ber_error_I, i_ber_error_Q;
    logic [3:0]  i_leds;
    logic        i_cmd_valid;
    logic [4:0]  i_cmd;
    logic        i_rack;
    logic [31:0] o_rdata;
    logic        o_rvalid, o_rerr, o_busy;

    int n_assert = 0;
    int n_fail   = 0;

    ber_readout #(.NB_BER_CNT(64), .NB_WORD(32), .NB_LEDS(4)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_ber_samp_I(i_ber_samp_I), .i_ber_samp_Q(i_ber_samp_Q),
        .i_ber_error_I(i_ber_error_I), .i_ber_error_Q(i_ber_error_Q),
        .i_leds(i_leds), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .i_rack(i_rack),
        .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_rerr(o_rerr), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction: command at edge N, o_rvalid low after N+1, high after N+2, then ack.
    task automatic txn(input logic [4:0] cmd, input logic [31:0] exp_d, input logic exp_e,
                       input string tag);
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd       = cmd;
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        chk({tag, "_busy_n"}, 64'(o_busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_rvalid_n1"}, 64'(o_rvalid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_rvalid_n2"}, 64'(o_rvalid), 64'd1);
        chk({tag, "_rdata"}, 64'(o_rdata), 64'(exp_d));
        chk({tag, "_rerr"}, 64'(o_rerr), 64'(exp_e));
        i_rack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rack = 1'b0;
        chk({tag, "_rvalid_ack"}, 64'(o_rvalid), 64'd0);
        chk({tag, "_busy_ack"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_ber_samp_I = '0; i_ber_samp_Q = '0; i_ber_error_I = '0; i_ber_error_Q = '0;
        i_leds = '0; i_cmd_valid = 1'b0; i_cmd = '0; i_rack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", 64'(o_rvalid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_rdata", 64'(o_rdata), 64'd0);
        chk("rst_rerr", 64'(o_rerr), 64'd0);
        i_rst = 1'b0;

        // Reads before any snapshot, and an out-of-range address
        txn(5'd8, 32'h0000_0000, 1'b0, "pre_status");
        txn(5'd0, 32'h0000_0000, 1'b0, "pre_w0");
        txn(5'd12, 32'hDEAD_BEEF, 1'b1, "bad_addr12");

        // First snapshot: cnt=1, leds=1010, valid=1
        i_ber_samp_I = 64'h0123_4567_89AB_CDEF;
        i_leds       = 4'b1010;
        txn(5'h10, 32'h0001_0015, 1'b0, "snap1");
        txn(5'd0, 32'h89AB_CDEF, 1'b0, "sampI_lo");
        txn(5'd1, 32'h0123_4567, 1'b0, "sampI_hi");
        txn(5'd8, 32'h0001_0015, 1'b0, "status1");

        // Second snapshot, then live counters move before reads
        i_ber_samp_Q  = 64'hAAAA_BBBB_CCCC_DDDD;
        i_ber_error_I = 64'hFEDC_BA98_7654_3210;
        i_ber_error_Q = 64'h1111_2222_3333_4444;
        txn(5'h10, 32'h0002_0015, 1'b0, "snap2");
        i_ber_samp_I  = 64'hFFFF_FFFF_FFFF_FFFF;
        i_ber_samp_Q  = 64'h5555_5555_5555_5555;
        i_ber_error_I = 64'h0;
        i_ber_error_Q = 64'h9999_9999_9999_9999;
        i_leds        = 4'b0101;
        txn(5'd4, 32'h7654_3210, 1'b0, "errI_lo_frozen");
        txn(5'd5, 32'hFEDC_BA98, 1'b0, "errI_hi_frozen");
        txn(5'd2, 32'hCCCC_DDDD, 1'b0, "sampQ_lo");
        txn(5'd7, 32'h1111_2222, 1'b0, "errQ_hi");
        txn(5'd15, 32'hDEAD_BEEF, 1'b1, "bad_addr15");

        // Ack outside RESP has no effect
        @(negedge clk);
        i_rack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rack = 1'b0;
        chk("idle_rack_rvalid", 64'(o_rvalid), 64'd0);

        // Response held under back-pressure while commands are pulsed
        i_cmd_valid = 1'b1;
        i_cmd       = 5'd6;
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        i_cmd = 5'h10;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_rvalid", 64'(o_rvalid), 64'd1);
            chk("hold_rdata", 64'(o_rdata), 64'h3333_4444);
            chk("hold_busy", 64'(o_busy), 64'd1);
            i_cmd_valid = ~i_cmd_valid;
            @(posedge clk);
        end
        @(negedge clk);
        i_rack      = 1'b1;
        i_cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rack      = 1'b0;
        i_cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("post_ack_rvalid", 64'(o_rvalid), 64'd0);
            chk("post_ack_busy", 64'(o_busy), 64'd0);
            @(negedge clk);
        end
        txn(5'd8, 32'h0002_0015, 1'b0, "no_extra_snap");

        // Reset asserted while in READ aborts the transaction
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd       = 5'd8;
        @(posedge clk);
        #2;
        i_cmd_valid = 1'b0;
        i_rst       = 1'b1;
        #1;
        chk("rst_read_rvalid", 64'(o_rvalid), 64'd0);
        chk("rst_read_busy", 64'(o_busy), 64'd0);
        chk("rst_read_rdata", 64'(o_rdata), 64'd0);
        @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        chk("rst_after_rvalid", 64'(o_rvalid), 64'd0);
        txn(5'd8, 32'h0000_0000, 1'b0, "post_rst_status");
        txn(5'd4, 32'h0000_0000, 1'b0, "post_rst_errI");

        // Snapshot counter wrap: 65534 back-to-back snapshots (4 cycles each), then two more
        @(negedge clk);
        i_cmd       = 5'h10;
        i_cmd_valid = 1'b1;
        i_rack      = 1'b1;
        repeat (65534 * 4) @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        i_rack      = 1'b0;
        chk("bulk_busy", 64'(o_busy), 64'd0);
        chk("bulk_rvalid", 64'(o_rvalid), 64'd0);
        txn(5'h10, 32'hFFFF_000B, 1'b0, "snap_ffff");
        txn(5'h10, 32'h0000_000B, 1'b0, "snap_wrap");
        txn(5'd8, 32'h0000_000B, 1'b0, "status_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
